proj_dot_accum: RTL

//  Streaming dot-product accumulator for the X_PROJ and delta_t_PROJ phases of the SSM.
//  - Consumes one weight/feature pair per beat; a vector ends on in_last.
//  - Multiplies each pair at full width and accumulates in a wide accumulator.
//  - Rounds, shifts and saturates the sum to DATA_WIDTH, then holds it in a

---
 rtl/proj_pkg.sv | 49 ++++
 rtl/proj_dot_accum_if.sv | 28 ++
 rtl/proj_dot_accum_chk.sv | 35 +++
 rtl/proj_dot_accum_requant_sat.sv | 28 ++
 rtl/proj_dot_accum.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/proj_pkg.sv
// Shared types and helpers for the SSM projection dot-product accumulator.
// Holds the accumulator state enum and the sizing, rounding and saturation helpers.
package proj_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_res_t;

    function automatic int acc_width(input int data_width, input int max_len);
        return 2 * data_width + $clog2(max_len);
    endfunction

    // Half an output LSB, added before the arithmetic shift so that ties round up.
    function automatic logic [63:0] round_half(input int frac_bits);
        logic [63:0] half_v;
        if (frac_bits > 0) begin
            half_v = 64'd1 << (frac_bits - 1);
        end else begin
            half_v = 64'd0;
        end
        return half_v;
    endfunction

    function automatic sat_res_t sat_signed(input logic signed [63:0] val, input int width);
        sat_res_t           res_v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (val > max_v) begin
            res_v.value = max_v;
            res_v.sat   = 1'b1;
        end else if (val < min_v) begin
            res_v.value = min_v;
            res_v.sat   = 1'b1;
        end else begin
            res_v.value = val;
            res_v.sat   = 1'b0;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/proj_dot_accum_if.sv
// Beat-stream input and valid/ready result channel of the projection accumulator.
interface proj_dot_accum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 9
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] a_in;
    logic signed [DATA_WIDTH-1:0] b_in;
    logic                         in_last;
    logic                         abort;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] result_out;
    logic [LEN_W-1:0]             out_len;
    logic                         out_sat;
    logic                         out_len_err;

    modport master (
        output in_valid, a_in, b_in, in_last, abort, out_ready,
        input  in_ready, out_valid, result_out, out_len, out_sat, out_len_err
    );

    modport slave (
        input  in_valid, a_in, b_in, in_last, abort, out_ready,
        output in_ready, out_valid, result_out, out_len, out_sat, out_len_err
    );
endinterface

// File: rtl/proj_dot_accum_chk.sv
// Checker for the projection accumulator: accumulator sizing and overflow.
module proj_dot_accum_chk
    import proj_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_LEN    = 256
) (
    input logic                        clk,
    input logic                        rst,
    input logic                        beat_i,
    input logic signed [ACC_WIDTH-1:0] acc_i,
    input logic signed [ACC_WIDTH-1:0] prod_i
);
    logic signed [ACC_WIDTH:0] wide_sum_s;

    // Exact sum with one extra bit, compared against its ACC_WIDTH truncation.
    always_comb begin
        wide_sum_s = (ACC_WIDTH + 1)'(acc_i) + (ACC_WIDTH + 1)'(prod_i);
    end

    // Accumulator must be wide enough for MAX_LEN full-scale products.
    always @(posedge clk) begin
        assert (ACC_WIDTH >= acc_width(DATA_WIDTH, MAX_LEN))
            else $error("proj_dot_accum: ACC_WIDTH too small for DATA_WIDTH/MAX_LEN");
    end

    // An accepted beat must never wrap the accumulator.
    always @(posedge clk) begin
        if (!rst && beat_i) begin
            assert (wide_sum_s == (ACC_WIDTH + 1)'(ACC_WIDTH'(wide_sum_s)))
                else $error("proj_dot_accum: accumulator overflow");
        end
    end
endmodule

// File: rtl/proj_dot_accum_requant_sat.sv
// Requantizer: round half up, arithmetic shift by FRAC_BITS, then clamp to DATA_WIDTH.
module requant_sat
    import proj_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  sum_i,
    output logic signed [DATA_WIDTH-1:0] res_o,
    output logic                         sat_o
);
    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    localparam logic signed [ACC_WIDTH:0] ROUND_C = (ACC_WIDTH + 1)'(round_half(FRAC_BITS));

    logic signed [ACC_WIDTH:0] biased_s;
    logic signed [ACC_WIDTH:0] shifted_s;
    sat_res_t                  sr_s;

    // Round, shift and saturate in one combinational pass.
    always_comb begin
        biased_s  = (ACC_WIDTH + 1)'(sum_i) + ROUND_C;
        shifted_s = biased_s >>> FRAC_BITS;
        sr_s      = sat_signed(64'(shifted_s), DATA_WIDTH);
        res_o     = DATA_WIDTH'(sr_s.value);
        sat_o     = sr_s.sat;
    end
endmodule

// File: rtl/proj_dot_accum.sv
// Streaming dot-product accumulator for the X_PROJ / delta_t_PROJ phases:
// multiply-accumulate per beat, requantize on the closing beat, hold in a valid/ready register.
module proj_dot_accum
    import proj_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8,
    parameter int MAX_LEN    = 256
) (
    input logic            clk,
    input logic            rst,
    proj_dot_accum_if.slave bus
);
    localparam int               LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_e                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]             cnt_q, cnt_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] result_q, result_d;
    logic [LEN_W-1:0]             out_len_q, out_len_d;
    logic                         out_sat_q, out_sat_d;
    logic                         out_len_err_q, out_len_err_d;

    logic                           in_ready_s;
    logic                           beat_s;
    logic                           last_beat_s;
    logic                           closing_s;
    logic [LEN_W-1:0]               cnt_inc_s;
    logic signed [2*DATA_WIDTH-1:0] prod_full_s;
    logic signed [ACC_WIDTH-1:0]    prod_s;
    logic signed [ACC_WIDTH-1:0]    base_s;
    logic signed [ACC_WIDTH-1:0]    sum_s;
    logic signed [DATA_WIDTH-1:0]   rq_res_s;
    logic                           rq_sat_s;

    // Handshake, full-width product and running sum for the current beat.
    always_comb begin
        in_ready_s  = !(out_valid_q && !bus.out_ready);
        beat_s      = bus.in_valid && in_ready_s;
        prod_full_s = (2 * DATA_WIDTH)'(bus.a_in) * (2 * DATA_WIDTH)'(bus.b_in);
        prod_s      = ACC_WIDTH'(prod_full_s);
        case (state_q)
            IDLE:    base_s = '0;
            ACC:     base_s = acc_q;
            default: base_s = '0;
        endcase
        sum_s       = base_s + prod_s;
        cnt_inc_s   = cnt_q + LEN_W'(1);
        last_beat_s = bus.in_last || (cnt_inc_s == MAX_LEN_C);
        closing_s   = beat_s && !bus.abort && last_beat_s;
    end

    requant_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_requant (
        .sum_i (sum_s),
        .res_o (rq_res_s),
        .sat_o (rq_sat_s)
    );

    // Accumulator, beat counter and state; abort wins over a simultaneous beat.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (beat_s) begin
            if (last_beat_s) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                acc_d   = sum_s;
                cnt_d   = cnt_inc_s;
            end
        end else begin
            state_d = state_q;
            acc_d   = acc_q;
            cnt_d   = cnt_q;
        end
    end

    // Result register: a closing beat reloads it even while the old result drains.
    always_comb begin
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        out_len_d     = out_len_q;
        out_sat_d     = out_sat_q;
        out_len_err_d = out_len_err_q;
        if (closing_s) begin
            out_valid_d   = 1'b1;
            result_d      = rq_res_s;
            out_len_d     = cnt_inc_s;
            out_sat_d     = rq_sat_s;
            out_len_err_d = !bus.in_last;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            out_len_q     <= '0;
            out_sat_q     <= 1'b0;
            out_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            out_len_q     <= out_len_d;
            out_sat_q     <= out_sat_d;
            out_len_err_q <= out_len_err_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.result_out  = result_q;
    assign bus.out_len     = out_len_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.out_len_err = out_len_err_q;

    proj_dot_accum_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .MAX_LEN    (MAX_LEN)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .beat_i (beat_s && !bus.abort),
        .acc_i  (base_s),
        .prod_i (prod_s)
    );
endmodule
